// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART image loader: framed bytes to instruction memory words, then CPU release
module uart_boot_loader #(
  parameter int WORD_BYTES     = 4,
  parameter int ADDR_WIDTH     = 12,
  parameter int MEM_BIG_ENDIAN = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic                    cpu_enable
);

  localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;
  localparam logic [7:0]  SYNC     = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t                  state;
  logic [7:0]              len_lo;
  logic [15:0]             remaining;
  logic [7:0]              csum;
  logic [LANE_W-1:0]       lane;
  logic [8*WORD_BYTES-1:0] asm_word;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [TO_W-1:0]         tcnt;

  logic [LANE_W-1:0]       lane_pos;
  logic [8*WORD_BYTES-1:0] word_next;
  logic [15:0]             len_full;
  logic                    active;
  logic                    last_byte;
  logic                    word_full;

  always_comb begin
    lane_pos  = (MEM_BIG_ENDIAN != 0) ? LANE_W'(WORD_BYTES - 1) - lane : lane;
    word_next = asm_word;
    word_next[{lane_pos, 3'b000} +: 8] = rx_data;
    len_full  = {rx_data, len_lo};
    active    = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                (state == S_DATA)   || (state == S_CSUM);
    last_byte = (remaining == 16'd1);
    word_full = (lane == LANE_W'(WORD_BYTES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len_lo     <= '0;
      remaining  <= '0;
      csum       <= '0;
      lane       <= '0;
      asm_word   <= '0;
      waddr      <= '0;
      tcnt       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
      cpu_enable <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (done) cpu_enable <= 1'b1;

      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (active && !rx_valid) begin
        if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state    <= S_ERROR;
          error    <= 1'b1;
          err_code <= 2'd3;
          busy     <= 1'b0;
          tcnt     <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else if (rx_valid) begin
        tcnt <= '0;
        case (state)
          S_IDLE: begin
            if (rx_data == SYNC) begin
              state <= S_LEN_LO;
              busy  <= 1'b1;
            end
          end
          S_LEN_LO: begin
            len_lo <= rx_data;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            if ({1'b0, len_full} > CAPACITY) begin
              state    <= S_ERROR;
              error    <= 1'b1;
              err_code <= 2'd1;
              busy     <= 1'b0;
            end else if (len_full == 16'd0) begin
              state <= S_CSUM;
            end else begin
              remaining <= len_full;
              state     <= S_DATA;
            end
          end
          S_DATA: begin
            csum      <= csum + rx_data;
            remaining <= remaining - 16'd1;
            if (word_full || last_byte) begin
              mem_we    <= 1'b1;
              mem_addr  <= waddr;
              mem_wdata <= word_next;
              waddr     <= waddr + ADDR_WIDTH'(WORD_BYTES);
              asm_word  <= '0;
              lane      <= '0;
            end else begin
              asm_word <= word_next;
              lane     <= lane + 1'b1;
            end
            if (last_byte) state <= S_CSUM;
          end
          S_CSUM: begin
            busy <= 1'b0;
            if (rx_data == csum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_ERROR;
              error    <= 1'b1;
              err_code <= 2'd2;
            end
          end
          S_ERROR: begin
            // Restart: a fresh sync byte reloads from address 0.
            if (rx_data == SYNC) begin
              state    <= S_LEN_LO;
              busy     <= 1'b1;
              error    <= 1'b0;
              err_code <= 2'd0;
              mem_addr <= '0;
              waddr    <= '0;
              csum     <= '0;
              asm_word <= '0;
              lane     <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Receives a framed program image byte-by-byte from the UART transceiver's receive side.
- Packs the bytes into memory words and writes them sequentially into instruction memory starting at byte address 0.
- Validates the image with a length field, an 8-bit checksum and an inter-byte timeout.
- Raises cpu_enable after a successful load, replacing bench-side program poking with a hardware load path.

Parameters:
- WORD_BYTES, 4: bytes per memory word; mem_wdata width is 8*WORD_BYTES.
- ADDR_WIDTH, 12: byte-address width of instruction memory; capacity is 2**ADDR_WIDTH bytes; legal range 2..16.
- MEM_BIG_ENDIAN, 1: 1 = first-arriving byte of a word goes to the MSB lane; 0 = first-arriving byte goes to the LSB lane.
- TIMEOUT_CYCLES, 100000: idle clock cycles allowed between bytes inside a frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte; valid only while rx_valid=1.
- rx_valid  input  1  single-cycle strobe, one per received byte.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  ADDR_WIDTH  byte address of the word; always a multiple of WORD_BYTES.
- mem_wdata  output  8*WORD_BYTES  word to write.
- busy  output  1  high while a frame is in progress.
- done  output  1  sticky; image loaded and checksum correct.
- error  output  1  sticky until restart or reset.
- err_code  output  2  0 none, 1 length exceeds capacity, 2 checksum mismatch, 3 timeout.
- cpu_enable  output  1  high from one cycle after done rises until rst.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0. State goes to IDLE. All counters, the length register, the checksum accumulator and the word assembly register are cleared. A reset mid-frame abandons the frame with no further writes.
- Frame format: sync byte 0xA5, LEN_LO, LEN_HI (16-bit payload byte count), LEN payload bytes, CSUM. CSUM is the sum of the payload bytes mod 256.
- IDLE: a byte equal to 0xA5 goes to LEN_LO and sets busy=1. Any other byte is ignored.
- LEN_LO: the byte captures len[7:0]; go to LEN_HI.
- LEN_HI: the byte captures len[15:8]. Next state:
  - len > 2**ADDR_WIDTH: ERROR with code 1.
  - len == 0: CSUM.
  - otherwise: DATA.
- DATA:
  - Each byte adds to the checksum and fills the next lane of the assembly register.
  - Lane k (0 = first byte of the word) maps to bits [8k+7:8k] when MEM_BIG_ENDIAN=0, and to [8(WORD_BYTES-1-k)+7 : 8(WORD_BYTES-1-k)] when 1.
  - When a word completes, or the last payload byte arrives: mem_we=1 for exactly one cycle, on the cycle after the accepting edge. mem_wdata carries the word with unfilled lanes set to 0.
  - mem_addr starts at 0 and increments by WORD_BYTES after each write.
  - After the last payload byte, go to CSUM.
- CSUM:
  - Received byte equals the accumulator: go to DONE; done=1, busy=0, cpu_enable=1 one cycle later.
  - Otherwise: ERROR with code 2.
- DONE: terminal until rst; all further bytes are ignored.
- ERROR: error=1, busy=0, err_code held. A received 0xA5 clears error and err_code to 0, clears mem_addr, the checksum and the lanes, and goes to LEN_LO. Other bytes are ignored.
- Timeout:
  - The counter runs in LEN_LO, LEN_HI, DATA and CSUM, and clears on every rx_valid.
  - Reaching TIMEOUT_CYCLES gives ERROR with code 3.
  - If rx_valid arrives on the same cycle as the expiry, the byte wins and the counter clears.
- mem_we never asserts outside DATA write cycles. Address wrap cannot occur because of the length check; a frame of exactly 2**ADDR_WIDTH bytes ends at the top word.
- rx_valid on consecutive cycles is legal. mem_we may coincide with acceptance of the next byte.

Test Plan:
- WORD_BYTES=4, MEM_BIG_ENDIAN=0; send A5 08 00 01 02 03 04 05 06 07 08 24 -> writes (0, 0x04030201) and (4, 0x08070605); done=1; cpu_enable=1 one cycle later; error=0.
- Same stream with MEM_BIG_ENDIAN=1 -> writes (0, 0x01020304) and (4, 0x05060708).
- Send A5 05 00 01 02 03 04 05 0F -> writes (0, 0x01020304) and (4, 0x05000000); done=1.
- Send A5 02 00 11 22 00 (bad CSUM) -> exactly one write, at addr 0; error=1, err_code=2, cpu_enable=0. Then send A5 02 00 11 22 33 -> error clears, rewrite at addr 0, done=1.
- ADDR_WIDTH=12; send A5 01 20 (len 0x2001) -> error=1, err_code=1, no mem_we. Send A5 00 10 (len 0x1000) followed by 4096 bytes and the correct CSUM -> last write at addr 0xFFC; done=1.
- TIMEOUT_CYCLES=50; send A5 04 00 01 and then go idle -> err_code=3 exactly 50 cycles after the last byte. Separately, assert rst mid-DATA -> all outputs 0 asynchronously and no writes afterwards.
